// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl_pkg
// Purpose  : Shared EX/MEM payload layout, memory size codes, MEM-stage FSM
//            state encoding and small lane/alignment helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_ctrl_pkg;

    // Total width of the EX/MEM pipeline payload.
    localparam int EXMEM_W = 109;

    // Width of the WAIT-state cycle counter.
    localparam int WAIT_CNT_W = 6;

    // MemSize field codes.
    typedef enum logic [1:0] {
        MSZ_WORD = 2'b00,
        MSZ_HALF = 2'b01,
        MSZ_BYTE = 2'b10,
        MSZ_RSVD = 2'b11
    } mem_size_e;

    // EX/MEM payload, MSB first. The packed layout fixes every field's bit
    // range, so the EX/MEM register and this stage cannot drift apart.
    typedef struct packed {
        logic        valid;        // [108]
        logic [31:0] pc_plus4;     // [107:76]
        logic        load_signed;  // [75]
        logic [1:0]  mem_size;     // [74:73]
        logic        mem_to_reg;   // [72]
        logic        mem_write;    // [71]
        logic        mem_read;     // [70]
        logic        reg_write;    // [69]
        logic [4:0]  dest_reg;     // [68:64]
        logic [31:0] store_data;   // [63:32]
        logic [31:0] alu_result;   // [31:0]
    } exmem_t;

    // MEM-stage controller states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Natural alignment check; the reserved size code never aligns.
    function automatic logic is_aligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic ok;
        case (size)
            MSZ_WORD: ok = (addr_lo == 2'b00);
            MSZ_HALF: ok = ~addr_lo[0];
            MSZ_BYTE: ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane enables for an aligned access.
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            MSZ_WORD: be = 4'b1111;
            MSZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
            MSZ_BYTE: be = 4'b0001 << addr_lo;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the low byte/half across all lanes so the memory can pick
    // whichever lane the byte enables select.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            MSZ_HALF: lanes = {2{data[15:0]}};
            MSZ_BYTE: lanes = {4{data[7:0]}};
            default:  lanes = data;
        endcase
        return lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_ctrl_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Selects the addressed byte/half lane from a 32-bit read word and
//            sign- or zero-extends it to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import mem_stage_ctrl_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [31:0] w_byte_shift;
    logic [31:0] w_half_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte_shift = i_rdata >> {i_addr_lo, 3'b000};
    assign w_half_shift = i_rdata >> {i_addr_lo[1], 4'b0000};
    assign w_byte       = w_byte_shift[7:0];
    assign w_half       = w_half_shift[15:0];

    // Extend the selected lane according to access size and signedness.
    always_comb begin
        o_data = i_rdata;
        case (i_size)
            MSZ_BYTE: o_data = i_signed ? {{24{w_byte[7]}}, w_byte}
                                        : {24'h000000, w_byte};
            MSZ_HALF: o_data = i_signed ? {{16{w_half[15]}}, w_half}
                                        : {16'h0000, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : MEM pipeline stage controller. Issues data-memory requests for
//            aligned loads/stores, stalls upstream while waiting for MemAck,
//            times out stuck accesses, flags misalignment and presents the
//            completed instruction on the write-back outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [EXMEM_W-1:0] ExMemData,
    output logic               Stall,
    output logic               MemReq,
    output logic               MemWe,
    output logic [31:0]        MemAddr,
    output logic [31:0]        MemWData,
    output logic [3:0]         MemBE,
    input  logic [31:0]        MemRData,
    input  logic               MemAck,
    output logic               WbValid,
    output logic               WbRegWrite,
    output logic               WbMemToReg,
    output logic [4:0]         WbDest,
    output logic [31:0]        WbReadData,
    output logic [31:0]        WbALUResult,
    output logic               AlignErr,
    output logic               BusErr
);

    // Counter value in the last permitted WAIT cycle.
    localparam logic [WAIT_CNT_W-1:0] c_last_wait = WAIT_CNT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_CNT_W-1:0] c_cnt_one   = WAIT_CNT_W'(1);

    exmem_t                w_pl;
    logic                  w_unused_pc;
    logic                  w_access;
    logic                  w_aligned;
    logic                  w_start;
    logic                  w_misalign;
    logic                  w_passthru;
    logic                  w_ack_done;
    logic                  w_wait_last;
    logic                  w_timeout;
    logic                  w_stall;
    logic [31:0]           w_req_alu;
    logic [31:0]           w_load_data;

    mem_state_e            r_state;
    mem_state_e            w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    // Outstanding request and the fields of the instruction that owns it.
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [3:0]            r_mem_be;
    logic [1:0]            r_req_lo;
    logic [1:0]            r_req_size;
    logic                  r_req_signed;
    logic                  r_req_write;
    logic [4:0]            r_req_dest;
    logic                  r_req_regwrite;
    logic                  r_req_memtoreg;

    // Write-back outputs.
    logic                  r_wb_valid;
    logic                  r_wb_regwrite;
    logic                  r_wb_memtoreg;
    logic [4:0]            r_wb_dest;
    logic [31:0]           r_wb_rdata;
    logic [31:0]           r_wb_alu;
    logic                  r_align_err;
    logic                  r_bus_err;

    assign w_pl        = ExMemData;
    // The return address travels through this stage untouched here.
    assign w_unused_pc = ^w_pl.pc_plus4;

    // A write wins when both MemRead and MemWrite are set.
    assign w_access    = w_pl.valid & (w_pl.mem_read | w_pl.mem_write);
    assign w_aligned   = is_aligned(w_pl.mem_size, w_pl.alu_result[1:0]);

    assign w_start     = (r_state == ST_IDLE) & w_access & w_aligned;
    assign w_misalign  = (r_state == ST_IDLE) & w_access & ~w_aligned;
    assign w_passthru  = (r_state == ST_IDLE) & w_pl.valid & ~w_access;

    // MemAck in the final WAIT cycle still counts as success.
    assign w_ack_done  = (r_state == ST_WAIT) & MemAck;
    assign w_wait_last = (r_state == ST_WAIT) & (r_wait_cnt == c_last_wait);
    assign w_timeout   = w_wait_last & ~MemAck;

    assign w_req_alu   = {r_mem_addr[31:2], r_req_lo};

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stall: stall from issue until the ack/timeout cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_WAIT;
                    w_stall     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (MemAck || w_wait_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (Rst) begin
            w_stall = 1'b0;
        end
    end

    // WAIT-cycle counter: cleared on issue, counts every WAIT cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wait_cnt <= '0;
        end else if (w_start) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_one;
        end
    end

    // Capture the request on issue and hold it stable until ack or timeout.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_be       <= '0;
            r_req_lo       <= '0;
            r_req_size     <= '0;
            r_req_signed   <= 1'b0;
            r_req_write    <= 1'b0;
            r_req_dest     <= '0;
            r_req_regwrite <= 1'b0;
            r_req_memtoreg <= 1'b0;
        end else if (w_start) begin
            r_mem_req      <= 1'b1;
            r_mem_we       <= w_pl.mem_write;
            r_mem_addr     <= {w_pl.alu_result[31:2], 2'b00};
            r_mem_wdata    <= store_lanes(w_pl.mem_size, w_pl.store_data);
            r_mem_be       <= byte_enable(w_pl.mem_size, w_pl.alu_result[1:0]);
            r_req_lo       <= w_pl.alu_result[1:0];
            r_req_size     <= w_pl.mem_size;
            r_req_signed   <= w_pl.load_signed;
            r_req_write    <= w_pl.mem_write;
            r_req_dest     <= w_pl.dest_reg;
            r_req_regwrite <= w_pl.reg_write;
            r_req_memtoreg <= w_pl.mem_to_reg;
        end else if (w_ack_done || w_timeout) begin
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
        end
    end

    load_align u_load_align (
        .i_rdata   (MemRData),
        .i_addr_lo (r_req_lo),
        .i_size    (r_req_size),
        .i_signed  (r_req_signed),
        .o_data    (w_load_data)
    );

    // Write-back: one-cycle valid after each completion, data held otherwise.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_memtoreg <= 1'b0;
            r_wb_dest     <= '0;
            r_wb_rdata    <= '0;
            r_wb_alu      <= '0;
            r_align_err   <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
            if (w_passthru) begin
                r_wb_valid    <= 1'b1;
                r_wb_regwrite <= w_pl.reg_write;
                r_wb_memtoreg <= w_pl.mem_to_reg;
                r_wb_dest     <= w_pl.dest_reg;
                r_wb_alu      <= w_pl.alu_result;
            end else if (w_misalign) begin
                r_wb_valid    <= 1'b1;
                r_wb_regwrite <= 1'b0;
                r_wb_memtoreg <= w_pl.mem_to_reg;
                r_wb_dest     <= w_pl.dest_reg;
                r_wb_alu      <= w_pl.alu_result;
                r_align_err   <= 1'b1;
            end else if (w_ack_done) begin
                r_wb_valid    <= 1'b1;
                r_wb_regwrite <= r_req_regwrite & ~r_req_write;
                r_wb_memtoreg <= r_req_memtoreg;
                r_wb_dest     <= r_req_dest;
                r_wb_alu      <= w_req_alu;
                if (!r_req_write) begin
                    r_wb_rdata <= w_load_data;
                end
            end else if (w_timeout) begin
                r_wb_valid    <= 1'b1;
                r_wb_regwrite <= 1'b0;
                r_wb_memtoreg <= r_req_memtoreg;
                r_wb_dest     <= r_req_dest;
                r_wb_alu      <= w_req_alu;
                r_bus_err     <= 1'b1;
            end
        end
    end

    assign Stall       = w_stall;
    assign MemReq      = r_mem_req;
    assign MemWe       = r_mem_we;
    assign MemAddr     = r_mem_addr;
    assign MemWData    = r_mem_wdata;
    assign MemBE       = r_mem_be;
    assign WbValid     = r_wb_valid;
    assign WbRegWrite  = r_wb_regwrite;
    assign WbMemToReg  = r_wb_memtoreg;
    assign WbDest      = r_wb_dest;
    assign WbReadData  = r_wb_rdata;
    assign WbALUResult = r_wb_alu;
    assign AlignErr    = r_align_err;
    assign BusErr      = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Self-checking bench for mem_stage_ctrl: directed scenarios plus
//            randomized instructions against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int c_max_wait = 16;

    logic         Clk;
    logic         Rst;
    logic [108:0] ExMemData;
    logic         Stall;
    logic         MemReq;
    logic         MemWe;
    logic [31:0]  MemAddr;
    logic [31:0]  MemWData;
    logic [3:0]   MemBE;
    logic [31:0]  MemRData;
    logic         MemAck;
    logic         WbValid;
    logic         WbRegWrite;
    logic         WbMemToReg;
    logic [4:0]   WbDest;
    logic [31:0]  WbReadData;
    logic [31:0]  WbALUResult;
    logic         AlignErr;
    logic         BusErr;

    int n_checks;
    int n_pass;
    int stall_cycles;

    mem_stage_ctrl #(.MAX_WAIT(c_max_wait)) u_dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .ExMemData   (ExMemData),
        .Stall       (Stall),
        .MemReq      (MemReq),
        .MemWe       (MemWe),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemBE       (MemBE),
        .MemRData    (MemRData),
        .MemAck      (MemAck),
        .WbValid     (WbValid),
        .WbRegWrite  (WbRegWrite),
        .WbMemToReg  (WbMemToReg),
        .WbDest      (WbDest),
        .WbReadData  (WbReadData),
        .WbALUResult (WbALUResult),
        .AlignErr    (AlignErr),
        .BusErr      (BusErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Payload in the documented bit layout: Valid at the top, ALUResult at the bottom.
    function automatic logic [108:0] make_pl(input logic v, input logic rd, input logic wr,
                                             input logic [1:0] sz, input logic sgn,
                                             input logic rw, input logic m2r,
                                             input logic [4:0] dest,
                                             input logic [31:0] alu, input logic [31:0] sd);
        logic [31:0] pc;
        pc = $urandom;
        return {v, pc, sgn, sz, m2r, wr, rd, rw, dest, sd, alu};
    endfunction

    function automatic logic [108:0] bubble();
        logic [108:0] b;
        b = {13'($urandom), $urandom, $urandom, $urandom};
        b[108] = 1'b0;
        return b;
    endfunction

    // One instruction: issue cycle, optional WAIT cycles answered at ack_at
    // (never, if beyond the limit), then a bubble cycle where the result is checked.
    task automatic do_instr(input logic [108:0] pl, input int ack_at, input logic [31:0] rdata);
        logic        valid, rd, wr, sgn, rw, m2r;
        logic [1:0]  sz;
        logic [4:0]  dest;
        logic [31:0] alu, sd, lane, exp_addr, exp_wd, exp_rd;
        logic [3:0]  exp_be;
        int          a, w;
        bit          access, aligned, memop, done, timed_out, exp_rw;

        alu   = pl[31:0];   sd  = pl[63:32]; dest = pl[68:64];
        rw    = pl[69];     rd  = pl[70];    wr   = pl[71];
        m2r   = pl[72];     sz  = pl[74:73]; sgn  = pl[75];
        valid = pl[108];

        a       = int'(alu % 4);
        access  = valid && (rd || wr);
        aligned = (sz == 2'd2) || (sz == 2'd1 && (a % 2) == 0) || (sz == 2'd0 && a == 0);
        memop   = access && aligned;

        exp_addr = alu - 32'(a);
        case (sz)
            2'd0:    begin exp_be = 4'hF;        exp_wd = sd; end
            2'd1:    begin exp_be = 4'h3 << a;   exp_wd = (sd & 32'hFFFF) * 32'h0001_0001; end
            default: begin exp_be = 4'h1 << a;   exp_wd = (sd & 32'hFF) * 32'h0101_0101; end
        endcase
        case (sz)
            2'd0: exp_rd = rdata;
            2'd1: begin
                lane   = (rdata >> (8 * a)) & 32'hFFFF;
                exp_rd = (sgn && lane >= 32'h8000) ? lane + 32'hFFFF_0000 : lane;
            end
            default: begin
                lane   = (rdata >> (8 * a)) & 32'hFF;
                exp_rd = (sgn && lane >= 32'h80) ? lane + 32'hFFFF_FF00 : lane;
            end
        endcase

        @(posedge Clk); #1;
        ExMemData = pl;
        MemAck    = 1'b0;
        MemRData  = $urandom;
        @(negedge Clk);
        if (Stall) stall_cycles++;
        chk("stall_issue", Stall, memop);
        chk("wbvalid_before", WbValid, 0);
        chk("memreq_before", MemReq, 0);
        chk("errs_before", {AlignErr, BusErr}, 0);

        timed_out = 0;
        if (memop) begin
            done = 0;
            w    = 0;
            while (!done) begin
                w++;
                @(posedge Clk); #1;
                MemAck   = (w == ack_at);
                MemRData = (w == ack_at) ? rdata : $urandom;
                @(negedge Clk);
                if (Stall) stall_cycles++;
                chk("memreq_wait", MemReq, 1);
                chk("memwe_wait", MemWe, wr);
                chk("memaddr_wait", MemAddr, exp_addr);
                chk("membe_wait", MemBE, exp_be);
                if (wr) chk("memwdata_wait", MemWData, exp_wd);
                chk("wbvalid_wait", WbValid, 0);
                if (w == ack_at) begin
                    done = 1;
                end else if (w == c_max_wait) begin
                    done      = 1;
                    timed_out = 1;
                end
                chk("stall_wait", Stall, !done);
            end
        end

        // Bubble cycle; a stray MemAck here must be ignored.
        @(posedge Clk); #1;
        ExMemData = bubble();
        MemAck    = 1'($urandom % 2);
        MemRData  = $urandom;
        @(negedge Clk);
        if (Stall) stall_cycles++;
        chk("stall_bubble", Stall, 0);
        if (!valid) begin
            chk("wbvalid_invalid", WbValid, 0);
        end else begin
            if (!access)             exp_rw = rw;
            else if (!aligned)       exp_rw = 0;
            else if (timed_out)      exp_rw = 0;
            else if (wr)             exp_rw = 0;
            else                     exp_rw = rw;
            chk("wbvalid", WbValid, 1);
            chk("wbdest", WbDest, dest);
            chk("wbalu", WbALUResult, alu);
            chk("wbregwrite", WbRegWrite, exp_rw);
            chk("memreq_after", MemReq, 0);
            chk("alignerr", AlignErr, access && !aligned);
            chk("buserr", BusErr, timed_out);
            if (!access || (memop && !timed_out)) chk("wbmemtoreg", WbMemToReg, m2r);
            if (memop && !timed_out && !wr) chk("wbreaddata", WbReadData, exp_rd);
        end
    endtask

    // Reset during the second WAIT cycle, together with a MemAck.
    task automatic do_reset_mid_wait();
        int busy;
        @(posedge Clk); #1;
        ExMemData = make_pl(1, 1, 0, 2'd0, 0, 1, 1, 5'd7, 32'h0000_0040, $urandom);
        MemAck    = 1'b0;
        @(negedge Clk);
        chk("rstw_stall_issue", Stall, 1);
        @(posedge Clk); #1;
        MemAck = 1'b0;
        @(negedge Clk);
        chk("rstw_memreq_w1", MemReq, 1);
        @(posedge Clk); #1;
        Rst    = 1'b1;
        MemAck = 1'b1;
        @(posedge Clk); #1;
        Rst       = 1'b0;
        MemAck    = 1'b0;
        ExMemData = '0;
        @(negedge Clk);
        chk("rstw_memreq", MemReq, 0);
        chk("rstw_stall", Stall, 0);
        chk("rstw_flags", {WbValid, BusErr, AlignErr, MemWe, MemBE}, 0);
        chk("rstw_addr", MemAddr, 0);
        @(posedge Clk); #1;
        MemAck = 1'b1;
        busy   = 0;
        for (int i = 0; i < c_max_wait + 2; i++) begin
            @(negedge Clk);
            if (WbValid || BusErr || MemReq || Stall) busy++;
            @(posedge Clk); #1;
            MemAck = 1'b0;
        end
        chk("rstw_quiet_after", busy, 0);
    endtask

    initial begin
        logic        v, rd, wr, sgn, rw, m2r;
        logic [1:0]  sz;
        int          ack_at;

        n_checks     = 0;
        n_pass       = 0;
        stall_cycles = 0;
        Rst          = 1'b1;
        ExMemData    = '0;
        MemAck       = 1'b0;
        MemRData     = '0;

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_ctrl", {Stall, MemReq, MemWe, MemBE, AlignErr, BusErr,
                           WbValid, WbRegWrite, WbMemToReg, WbDest}, 0);
        chk("reset_addr", MemAddr, 0);
        chk("reset_wdata", MemWData, 0);
        chk("reset_rdata", WbReadData, 0);
        chk("reset_alu", WbALUResult, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        // Plain ALU op flows through with no stall.
        stall_cycles = 0;
        do_instr(make_pl(1, 0, 0, 2'd0, 0, 1, 0, 5'd5, 32'h0000_1234, $urandom), 1, 0);
        chk("aluop_no_stall", stall_cycles, 0);
        chk("aluop_wbalu", WbALUResult, 32'h0000_1234);

        // Signed byte load from lane 3, ack in the third WAIT cycle.
        stall_cycles = 0;
        do_instr(make_pl(1, 1, 0, 2'd2, 1, 1, 1, 5'd9, 32'h0000_0103, $urandom), 3, 32'h80FF_FF00);
        chk("bload_stall_cycles", stall_cycles, 3);
        chk("bload_rdata", WbReadData, 32'hFFFF_FF80);

        // Half store to upper lanes.
        do_instr(make_pl(1, 0, 1, 2'd1, 0, 1, 0, 5'd3, 32'h0000_0022, 32'h1234_BEEF), 2, 0);

        // Misaligned word load.
        stall_cycles = 0;
        do_instr(make_pl(1, 1, 0, 2'd0, 0, 1, 1, 5'd4, 32'h0000_0006, $urandom), 1, 0);
        chk("misalign_no_stall", stall_cycles, 0);

        // No ack at all: bus timeout.
        do_instr(make_pl(1, 1, 0, 2'd0, 0, 1, 1, 5'd6, 32'h0000_0100, $urandom), 1000, 0);

        // Ack exactly in the final WAIT cycle is a success.
        do_instr(make_pl(1, 1, 0, 2'd1, 0, 1, 1, 5'd8, 32'h0000_0202, $urandom), c_max_wait, 32'h8001_7FFE);

        // Read+write together behaves as a write; reserved size is misaligned.
        do_instr(make_pl(1, 1, 1, 2'd0, 0, 1, 0, 5'd10, 32'h0000_0010, 32'hCAFE_F00D), 1, 0);
        do_instr(make_pl(1, 1, 0, 2'd3, 0, 1, 0, 5'd11, 32'h0000_0020, $urandom), 1, 0);

        do_reset_mid_wait();

        for (int i = 0; i < 200; i++) begin
            v   = ($urandom % 8) != 0;
            rd  = 1'($urandom % 2);
            wr  = 1'($urandom % 2);
            sz  = 2'($urandom % 4);
            sgn = 1'($urandom % 2);
            rw  = 1'($urandom % 2);
            m2r = 1'($urandom % 2);
            if (($urandom % 8) == 0) ack_at = $urandom_range(c_max_wait + 3, c_max_wait - 2);
            else                     ack_at = $urandom_range(6, 1);
            do_instr(make_pl(v, rd, wr, sz, sgn, rw, m2r, 5'($urandom), $urandom, $urandom),
                     ack_at, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, max WAIT-state cycles before bus timeout.
REQ-002 SHALL have port Clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port Rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port ExMemData  in  109  EX/MEM payload: [31:0] ALUResult, [63:32] StoreData, [68:64] DestReg, [69] RegWrite, [70] MemRead, [71] MemWrite, [72] MemToReg, [74:73] MemSize (00 word, 01 half, 10 byte), [75] LoadSigned, [107:76] PCPlus4, [108] Valid.
REQ-005 SHALL have port Stall  out  1  high = upstream pipeline registers hold; drives their WriteReg low.
REQ-006 SHALL have ports MemReq/MemWe  out  1/1  data-memory request and write strobe.
REQ-007 SHALL have ports MemAddr/MemWData/MemBE  out  32/32/4  word-aligned address, lane-replicated store data, byte enables.
REQ-008 SHALL have ports MemRData/MemAck  in  32/1  read data, one-cycle completion pulse.
REQ-009 SHALL have ports WbValid, WbRegWrite, WbMemToReg  out  1 each; WbDest  out  5; WbReadData, WbALUResult  out  32 each.
REQ-010 SHALL have ports AlignErr, BusErr  out  1 each  one-cycle fault pulses.

Function
REQ-011 SHALL implement FSM with states IDLE and WAIT.
REQ-012 Access = Valid & (MemRead | MemWrite); MemRead and MemWrite both set SHALL be treated as a write.
REQ-013 In IDLE, a non-access Valid payload SHALL appear on Wb* outputs one cycle later with WbValid=1 and Stall=0.
REQ-014 In IDLE, an aligned access SHALL raise Stall combinationally the same cycle and enter WAIT with MemReq=1, MemWe, MemAddr={ALUResult[31:2],2'b00}, MemBE and MemWData registered.
REQ-015 Alignment: word requires addr[1:0]=00, half requires addr[0]=0, byte always aligned; MemSize=11 SHALL be treated as misaligned.
REQ-016 Misaligned access SHALL issue no request, pulse AlignErr next cycle, and produce WbValid=1 with WbRegWrite=0, no stall.
REQ-017 MemBE SHALL be 1111 for word, 0011<<(2*addr[1]) for half, 0001<<addr[1:0] for byte; MemWData SHALL replicate low byte/half across lanes.
REQ-018 In WAIT, MemReq and all request fields SHALL hold stable until MemAck; Stall SHALL remain 1 except in the MemAck cycle, where it SHALL be 0.
REQ-019 On MemAck, the FSM SHALL return to IDLE and next cycle present WbValid=1; loads SHALL put the selected lane, sign-extended if LoadSigned else zero-extended, on WbReadData.
REQ-020 Stores SHALL complete with WbRegWrite=0.
REQ-021 A 6-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle; reaching MAX_WAIT without MemAck SHALL return to IDLE, deassert MemReq, pulse BusErr, and emit WbValid=1 with WbRegWrite=0.
REQ-022 MemAck in the same cycle the counter reaches MAX_WAIT SHALL count as success, no BusErr.
REQ-023 MemAck while in IDLE SHALL be ignored.
REQ-024 WbValid SHALL be 0 in any cycle not following a completion; Wb* data SHALL hold their last values otherwise.

Reset
REQ-025 On Rst sampled high, state=IDLE, counter=0, and all outputs SHALL be 0 after that edge, including mid-WAIT; an outstanding request SHALL be abandoned.
REQ-026 Rst SHALL take priority over MemAck and ExMemData in the same cycle.

Structure
REQ-027 Payload field bit ranges, MemSize codes, and state encodings SHALL reside in a shared package/header used by both the EX/MEM register and this block.
REQ-028 Load lane extraction/extension SHALL be a sub-module named load_align.

Verification
REQ-029 Non-memory op ALUResult=0x1234, DestReg=5, RegWrite=1 -> next cycle WbValid=1, WbALUResult=0x1234, WbDest=5, Stall never high.
REQ-030 Byte load addr 0x103, LoadSigned=1, MemAck after 3 WAIT cycles with MemRData=0x80FF_FF00 -> MemBE=1000, Stall high 3 cycles, WbReadData=0xFFFF_FF80.
REQ-031 Half store addr 0x22, StoreData=0xBEEF -> MemWe=1, MemBE=1100, MemWData=0xBEEF_BEEF, WbRegWrite=0.
REQ-032 Word load addr 0x06 -> no MemReq, AlignErr pulse, WbRegWrite=0, Stall 0.
REQ-033 No MemAck for 16 WAIT cycles -> MemReq drops, BusErr one pulse, Stall releases.
REQ-034 Rst in 2nd WAIT cycle -> next cycle MemReq=0, Stall=0, IDLE; later MemAck ignored.
